// File: rtl/prefetch_data_queue.sv
// Prefetch data queue: circular buffer of prefetch slots. Allocates prefetch
// addresses, issues them to memory in order, collects fills, and answers
// demand lookups with hit/data, popping everything up to the matched slot.
//
// Memory request handshake: memReqValid/memReqAddr/memReqTag describe slot[iss]
// and stay stable while memReqValid && !memReqReady; a request transfers on a
// rising edge where both memReqValid and memReqReady are 1. Responses have no
// ready and are always accepted, even while en=0.
module prefetch_data_queue #(
    parameter int ADDR_BITS       = 64,
    parameter int DATA_BITS       = 64,
    parameter int QUEUE_DEPTH     = 8,
    parameter int LOG_QUEUE_DEPTH = 3,
    parameter int ALMOST_FULL_TH  = 6
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       en,
    input  logic                       flushN,
    input  logic                       pfAddrValid,
    input  logic [ADDR_BITS-1:0]       pfAddr,
    output logic                       memReqValid,
    output logic [ADDR_BITS-1:0]       memReqAddr,
    output logic [LOG_QUEUE_DEPTH-1:0] memReqTag,
    input  logic                       memReqReady,
    input  logic                       memRespValid,
    input  logic [LOG_QUEUE_DEPTH-1:0] memRespTag,
    input  logic [DATA_BITS-1:0]       memRespData,
    input  logic                       inAddrReqValid,
    input  logic [ADDR_BITS-1:0]       inAddrReq,
    output logic                       addrReqHit,
    output logic                       hitDataValid,
    output logic [DATA_BITS-1:0]       hitData,
    output logic                       almostFull,
    output logic                       full,
    output logic                       empty,
    output logic [LOG_QUEUE_DEPTH:0]   outstandingReqCnt,
    // Per-slot state (3 bits per slot, slot 0 in the LSBs) and pointers.
    output logic [3*QUEUE_DEPTH-1:0]   dbg_slot_state,
    output logic [LOG_QUEUE_DEPTH-1:0] dbg_head,
    output logic [LOG_QUEUE_DEPTH-1:0] dbg_tail,
    output logic [LOG_QUEUE_DEPTH-1:0] dbg_iss
);

    typedef enum logic [2:0] {
        SLOT_EMPTY    = 3'd0,
        SLOT_PENDING  = 3'd1,
        SLOT_INFLIGHT = 3'd2,
        SLOT_VALID    = 3'd3,
        SLOT_ORPHAN   = 3'd4
    } slot_state_t;

    typedef logic [LOG_QUEUE_DEPTH-1:0] ptr_t;
    localparam int CNT_BITS = LOG_QUEUE_DEPTH + 1;
    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] AF_TH = CNT_BITS'(ALMOST_FULL_TH);

    slot_state_t          state_q [QUEUE_DEPTH];
    slot_state_t          state_n [QUEUE_DEPTH];
    logic [ADDR_BITS-1:0] addr_q  [QUEUE_DEPTH];
    logic [DATA_BITS-1:0] data_q  [QUEUE_DEPTH];

    ptr_t head_q, tail_q, iss_q;
    ptr_t head_n, tail_n, iss_n;
    ptr_t iss_off;

    logic                almost_full_q, full_q, empty_q;
    logic [CNT_BITS-1:0] out_cnt_q;
    logic                almost_full_n, full_n, empty_n;
    logic [CNT_BITS-1:0] occ_n, out_cnt_n;

    logic match_found;
    ptr_t match_off;
    ptr_t match_idx;

    logic push_fire, issue_fire, pop_fire, flush_now, fill_ok;

    // Lookup scan from head outward; scanning backwards lets the nearest-head match win.
    always_comb begin
        match_found = 1'b0;
        match_off   = '0;
        match_idx   = '0;
        for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
            if (state_q[head_q + ptr_t'(i)] != SLOT_EMPTY &&
                state_q[head_q + ptr_t'(i)] != SLOT_ORPHAN &&
                addr_q[head_q + ptr_t'(i)] == inAddrReq) begin
                match_found = 1'b1;
                match_off   = ptr_t'(i);
                match_idx   = head_q + ptr_t'(i);
            end
        end
    end

    // Output decode: lookup result, memory request and registered status flags.
    always_comb begin
        addrReqHit        = en && inAddrReqValid && match_found;
        hitDataValid      = addrReqHit && (state_q[match_idx] == SLOT_VALID);
        hitData           = hitDataValid ? data_q[match_idx] : '0;
        memReqValid       = en && flushN && (state_q[iss_q] == SLOT_PENDING);
        memReqAddr        = memReqValid ? addr_q[iss_q] : '0;
        memReqTag         = iss_q;
        almostFull        = almost_full_q;
        full              = full_q;
        empty             = empty_q;
        outstandingReqCnt = out_cnt_q;
        dbg_head          = head_q;
        dbg_tail          = tail_q;
        dbg_iss           = iss_q;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            dbg_slot_state[3*i +: 3] = state_q[i];
        end
    end

    // Events that can change the queue this cycle.
    always_comb begin
        flush_now  = en && !flushN;
        push_fire  = pfAddrValid && en && flushN && !full_q;
        issue_fire = memReqValid && memReqReady;
        pop_fire   = hitDataValid && flushN;
        fill_ok    = memRespValid && (state_q[memRespTag] == SLOT_INFLIGHT);
    end

    // Next slot states and pointers. Fill is applied first so that a fill
    // landing together with a flush or pop on the same slot ends up EMPTY.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            state_n[i] = state_q[i];
        end
        head_n  = head_q;
        tail_n  = tail_q;
        iss_n   = iss_q;
        iss_off = '0;

        if (memRespValid) begin
            case (state_q[memRespTag])
                SLOT_INFLIGHT: state_n[memRespTag] = SLOT_VALID;
                SLOT_ORPHAN:   state_n[memRespTag] = SLOT_EMPTY;
                default:       ;
            endcase
        end

        if (flush_now) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                case (state_n[i])
                    SLOT_PENDING, SLOT_VALID: state_n[i] = SLOT_EMPTY;
                    SLOT_INFLIGHT:            state_n[i] = SLOT_ORPHAN;
                    default:                  ;
                endcase
            end
            head_n = tail_q;
            iss_n  = tail_q;
        end else begin
            if (issue_fire) begin
                state_n[iss_q] = SLOT_INFLIGHT;
                iss_n          = iss_q + PTR_ONE;
            end
            if (push_fire) begin
                state_n[tail_q] = SLOT_PENDING;
                tail_n          = tail_q + PTR_ONE;
            end
            if (pop_fire) begin
                // Discard head..match; requests already out become orphans.
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    if (ptr_t'(i) <= match_off) begin
                        case (state_n[head_q + ptr_t'(i)])
                            SLOT_PENDING, SLOT_VALID: state_n[head_q + ptr_t'(i)] = SLOT_EMPTY;
                            SLOT_INFLIGHT:            state_n[head_q + ptr_t'(i)] = SLOT_ORPHAN;
                            default:                  ;
                        endcase
                    end
                end
                head_n  = match_idx + PTR_ONE;
                // iss == tail means nothing left to issue; it must not be dragged past tail.
                iss_off = iss_n - head_q;
                if (iss_n != tail_q && iss_off <= match_off) begin
                    iss_n = match_idx + PTR_ONE;
                end
            end
        end
    end

    // Status flags derived from next state so they settle one cycle after an event.
    always_comb begin
        occ_n     = '0;
        out_cnt_n = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (state_n[i] != SLOT_EMPTY) begin
                occ_n = occ_n + CNT_ONE;
            end
            if (state_n[i] == SLOT_INFLIGHT || state_n[i] == SLOT_ORPHAN) begin
                out_cnt_n = out_cnt_n + CNT_ONE;
            end
        end
        almost_full_n = (occ_n >= AF_TH);
        empty_n       = (occ_n == '0);
        full_n        = (state_n[tail_n] != SLOT_EMPTY);
    end

    // Control state register: slot states, pointers, status flags.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                state_q[i] <= SLOT_EMPTY;
            end
            head_q        <= '0;
            tail_q        <= '0;
            iss_q         <= '0;
            almost_full_q <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            out_cnt_q     <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                state_q[i] <= state_n[i];
            end
            head_q        <= head_n;
            tail_q        <= tail_n;
            iss_q         <= iss_n;
            almost_full_q <= almost_full_n;
            full_q        <= full_n;
            empty_q       <= empty_n;
            out_cnt_q     <= out_cnt_n;
        end
    end

    // Payload storage; only read when the slot state says it is meaningful.
    always_ff @(posedge clk) begin
        if (push_fire && !flush_now) begin
            addr_q[tail_q] <= pfAddr;
        end
        if (fill_ok) begin
            data_q[memRespTag] <= memRespData;
        end
    end

endmodule

// File: tb/tb_prefetch_data_queue.sv
// Bench for prefetch_data_queue: directed sequences for push/issue/fill/pop,
// flush, full/almostFull, reset mid-flight, plus a lookup vector table.
module tb_prefetch_data_queue;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LQ = 3;
    localparam int W  = AW + LQ;

    localparam logic [2:0] S_EMPTY    = 3'd0;
    localparam logic [2:0] S_PENDING  = 3'd1;
    localparam logic [2:0] S_INFLIGHT = 3'd2;
    localparam logic [2:0] S_VALID    = 3'd3;
    localparam logic [2:0] S_ORPHAN   = 3'd4;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          en = 1'b1;
    logic          flushN = 1'b1;
    logic          pfAddrValid = 1'b0;
    logic [AW-1:0] pfAddr = '0;
    logic          memReqValid;
    logic [AW-1:0] memReqAddr;
    logic [LQ-1:0] memReqTag;
    logic          memReqReady = 1'b0;
    logic          memRespValid = 1'b0;
    logic [LQ-1:0] memRespTag = '0;
    logic [DW-1:0] memRespData = '0;
    logic          inAddrReqValid = 1'b0;
    logic [AW-1:0] inAddrReq = '0;
    logic          addrReqHit;
    logic          hitDataValid;
    logic [DW-1:0] hitData;
    logic          almostFull;
    logic          full;
    logic          empty;
    logic [LQ:0]   outstandingReqCnt;
    logic [23:0]   dbg_slot_state;
    logic [LQ-1:0] dbg_head;
    logic [LQ-1:0] dbg_tail;
    logic [LQ-1:0] dbg_iss;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic          en;
        logic          valid;
        logic [AW-1:0] addr;
        logic          exp_hit;
        logic          exp_hdv;
        logic [DW-1:0] exp_data;
    } lk_vec_t;

    lk_vec_t lk_tab[6];

    prefetch_data_queue dut (
        .clk(clk), .resetN(resetN), .en(en), .flushN(flushN),
        .pfAddrValid(pfAddrValid), .pfAddr(pfAddr),
        .memReqValid(memReqValid), .memReqAddr(memReqAddr), .memReqTag(memReqTag),
        .memReqReady(memReqReady),
        .memRespValid(memRespValid), .memRespTag(memRespTag), .memRespData(memRespData),
        .inAddrReqValid(inAddrReqValid), .inAddrReq(inAddrReq),
        .addrReqHit(addrReqHit), .hitDataValid(hitDataValid), .hitData(hitData),
        .almostFull(almostFull), .full(full), .empty(empty),
        .outstandingReqCnt(outstandingReqCnt),
        .dbg_slot_state(dbg_slot_state), .dbg_head(dbg_head),
        .dbg_tail(dbg_tail), .dbg_iss(dbg_iss)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_slot(input string name, input int idx, input logic [2:0] exp);
        check(name, {61'd0, dbg_slot_state[3*idx +: 3]}, {61'd0, exp});
    endtask

    // Drive one push for the next edge; optionally expect it on the request port later.
    task automatic push_one(input logic [AW-1:0] a, input logic [LQ-1:0] tag, input bit expect_issue);
        pfAddrValid = 1'b1;
        pfAddr      = a;
        if (expect_issue) exp_q.push_back({a, tag});
        tick();
    endtask

    task automatic resp(input logic [LQ-1:0] tag, input logic [DW-1:0] d);
        memRespValid = 1'b1;
        memRespTag   = tag;
        memRespData  = d;
        tick();
        memRespValid = 1'b0;
    endtask

    // Lookup that is expected to hit a VALID slot and pop through it.
    task automatic lookup_pop(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
        inAddrReqValid = 1'b1;
        inAddrReq      = a;
        #1;
        check({name, "_hit"}, {63'd0, addrReqHit}, 64'd1);
        check({name, "_hdv"}, {63'd0, hitDataValid}, 64'd1);
        check({name, "_data"}, hitData, d);
        tick();
        inAddrReqValid = 1'b0;
    endtask

    initial begin
        lk_tab[0] = '{1'b1, 1'b1, 64'h2000, 1'b1, 1'b1, 64'h11};
        lk_tab[1] = '{1'b1, 1'b1, 64'h2040, 1'b1, 1'b1, 64'h22};
        lk_tab[2] = '{1'b1, 1'b1, 64'h2080, 1'b1, 1'b0, 64'h0};
        lk_tab[3] = '{1'b1, 1'b1, 64'h3000, 1'b0, 1'b0, 64'h0};
        lk_tab[4] = '{1'b0, 1'b1, 64'h2000, 1'b0, 1'b0, 64'h0};
        lk_tab[5] = '{1'b1, 1'b0, 64'h2000, 1'b0, 1'b0, 64'h0};

        // Scoreboard: every accepted memory request must match the oldest expected one.
        fork
            forever begin
                logic [W-1:0] e;
                @(negedge clk);
                if (resetN && memReqValid && memReqReady) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_req_unexpected: got addr 0x%0h tag %0d, expected none",
                                 memReqAddr, memReqTag);
                    end else begin
                        e = exp_q.pop_front();
                        check("mem_req_addr", memReqAddr, e[W-1:LQ]);
                        check("mem_req_tag", {61'd0, memReqTag}, {61'd0, e[LQ-1:0]});
                    end
                end
            end
        join_none

        // Reset
        repeat (3) tick();
        resetN = 1'b1;
        #1;
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_af", {63'd0, almostFull}, 64'd0);
        check("rst_cnt", {59'd0, outstandingReqCnt}, 64'd0);
        check("rst_req_valid", {63'd0, memReqValid}, 64'd0);
        check("rst_hit", {63'd0, addrReqHit}, 64'd0);
        tick();

        // Two pushes issued back to back
        memReqReady = 1'b1;
        push_one(64'h1000, 3'd0, 1'b1);
        push_one(64'h1040, 3'd1, 1'b1);
        pfAddrValid = 1'b0;
        tick();
        memReqReady = 1'b0;
        check("t1_cnt", {59'd0, outstandingReqCnt}, 64'd2);
        check("t1_sb_drained", 64'(exp_q.size()), 64'd0);
        check_slot("t1_slot1", 1, S_INFLIGHT);

        // Fill, then lookup pops the head slot
        resp(3'd0, 64'hAA);
        lookup_pop("t2", 64'h1000, 64'hAA);
        check("t2_head", {61'd0, dbg_head}, 64'd1);
        check("t2_cnt", {59'd0, outstandingReqCnt}, 64'd1);
        check("t2_empty", {63'd0, empty}, 64'd0);
        check_slot("t2_slot0", 0, S_EMPTY);
        resp(3'd1, 64'h55);
        lookup_pop("t2b", 64'h1040, 64'h55);
        check("t2_empty_after", {63'd0, empty}, 64'd1);

        // INFLIGHT, VALID, PENDING; hit on the VALID one orphans the older request
        memReqReady = 1'b1;
        push_one(64'h1100, 3'd2, 1'b1);
        push_one(64'h1080, 3'd3, 1'b1);
        push_one(64'h1140, 3'd4, 1'b0);
        pfAddrValid = 1'b0;
        memReqReady = 1'b0;
        resp(3'd3, 64'hBB);
        lookup_pop("t3", 64'h1080, 64'hBB);
        check_slot("t3_slot2", 2, S_ORPHAN);
        check_slot("t3_slot3", 3, S_EMPTY);
        check_slot("t3_slot4", 4, S_PENDING);
        check("t3_head", {61'd0, dbg_head}, 64'd4);
        check("t3_iss", {61'd0, dbg_iss}, 64'd4);
        check("t3_cnt", {59'd0, outstandingReqCnt}, 64'd1);
        check("t3_req_addr_hold", memReqAddr, 64'h1140);
        // Hit on a PENDING slot: no pop
        inAddrReqValid = 1'b1;
        inAddrReq      = 64'h1140;
        #1;
        check("t3_pend_hit", {63'd0, addrReqHit}, 64'd1);
        check("t3_pend_hdv", {63'd0, hitDataValid}, 64'd0);
        check("t3_pend_data", hitData, 64'd0);
        tick();
        inAddrReqValid = 1'b0;
        check("t3_head_kept", {61'd0, dbg_head}, 64'd4);
        resp(3'd2, 64'hDEAD);
        check_slot("t3_orphan_freed", 2, S_EMPTY);
        exp_q.push_back({64'h1140, 3'd4});
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        resp(3'd4, 64'hCC);
        lookup_pop("t3c", 64'h1140, 64'hCC);
        check("t3_empty", {63'd0, empty}, 64'd1);

        // Flush with two INFLIGHT and one PENDING
        memReqReady = 1'b1;
        push_one(64'h2000, 3'd5, 1'b1);
        push_one(64'h2040, 3'd6, 1'b1);
        push_one(64'h2100, 3'd7, 1'b0);
        pfAddrValid = 1'b0;
        memReqReady = 1'b0;
        check("t4_req_before", {63'd0, memReqValid}, 64'd1);
        flushN = 1'b0;
        #1;
        check("t4_req_during", {63'd0, memReqValid}, 64'd0);
        tick();
        flushN = 1'b1;
        check("t4_cnt", {59'd0, outstandingReqCnt}, 64'd2);
        check("t4_empty", {63'd0, empty}, 64'd0);
        check_slot("t4_slot5", 5, S_ORPHAN);
        check_slot("t4_slot7", 7, S_EMPTY);
        check("t4_head", {61'd0, dbg_head}, 64'd0);
        check("t4_iss", {61'd0, dbg_iss}, 64'd0);
        inAddrReqValid = 1'b1;
        inAddrReq      = 64'h2000;
        #1;
        check("t4_miss", {63'd0, addrReqHit}, 64'd0);
        inAddrReqValid = 1'b0;
        resp(3'd5, 64'h1);
        resp(3'd6, 64'h2);
        check("t4_empty_after", {63'd0, empty}, 64'd1);
        check("t4_cnt_after", {59'd0, outstandingReqCnt}, 64'd0);

        // Fill to full with memory stalled
        for (int k = 0; k < 8; k++) begin
            logic [AW-1:0] a;
            a = 64'h3000 + 64'(k) * 64'h40;
            push_one(a, 3'(k), 1'b1);
            check($sformatf("t5_af_%0d", k + 1), {63'd0, almostFull}, 64'((k + 1) >= 6));
            check($sformatf("t5_full_%0d", k + 1), {63'd0, full}, 64'((k + 1) == 8));
        end
        push_one(64'hDEAD0000, 3'd0, 1'b0);
        pfAddrValid = 1'b0;
        check("t5_full_kept", {63'd0, full}, 64'd1);
        check("t5_all_pending", {40'd0, dbg_slot_state}, {40'd0, {8{S_PENDING}}});
        check("t5_req_addr", memReqAddr, 64'h3000);
        check("t5_req_tag", {61'd0, memReqTag}, 64'd0);
        memReqReady = 1'b1;
        repeat (8) tick();
        memReqReady = 1'b0;
        check("t5_cnt", {59'd0, outstandingReqCnt}, 64'd8);
        check("t5_sb_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of outstanding traffic
        #2;
        resetN = 1'b0;
        #1;
        check("t6_empty", {63'd0, empty}, 64'd1);
        check("t6_full", {63'd0, full}, 64'd0);
        check("t6_af", {63'd0, almostFull}, 64'd0);
        check("t6_cnt", {59'd0, outstandingReqCnt}, 64'd0);
        check("t6_req_valid", {63'd0, memReqValid}, 64'd0);
        tick();
        resetN = 1'b1;
        resp(3'd3, 64'h77);
        check("t6_stale_empty", {63'd0, empty}, 64'd1);
        check("t6_stale_slots", {40'd0, dbg_slot_state}, 64'd0);

        // Push while disabled is ignored
        en          = 1'b0;
        pfAddrValid = 1'b1;
        pfAddr      = 64'h4000;
        tick();
        pfAddrValid = 1'b0;
        en          = 1'b1;
        check("en0_push_empty", {63'd0, empty}, 64'd1);
        check("en0_push_slots", {40'd0, dbg_slot_state}, 64'd0);

        // Lookup table setup: slots 0,1,3 VALID, slot 2 INFLIGHT, 0x2040 duplicated
        memReqReady = 1'b1;
        push_one(64'h2000, 3'd0, 1'b1);
        push_one(64'h2040, 3'd1, 1'b1);
        push_one(64'h2080, 3'd2, 1'b1);
        push_one(64'h2040, 3'd3, 1'b1);
        pfAddrValid = 1'b0;
        tick();
        memReqReady = 1'b0;
        resp(3'd0, 64'h11);
        resp(3'd1, 64'h22);
        resp(3'd3, 64'h44);
        for (int v = 0; v < 6; v++) begin
            en             = lk_tab[v].en;
            inAddrReqValid = lk_tab[v].valid;
            inAddrReq      = lk_tab[v].addr;
            #1;
            check($sformatf("lk%0d_hit", v), {63'd0, addrReqHit}, {63'd0, lk_tab[v].exp_hit});
            check($sformatf("lk%0d_hdv", v), {63'd0, hitDataValid}, {63'd0, lk_tab[v].exp_hdv});
            check($sformatf("lk%0d_data", v), hitData, lk_tab[v].exp_data);
            inAddrReqValid = 1'b0;
            en             = 1'b1;
            tick();
        end
        check("final_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
